// File: rtl/digit_entry_display_pkg.sv
// Shared constants and the anode pattern helper for the digit entry display.
package digit_display_pkg;

    localparam int unsigned MAX_DIGITS         = 8;
    localparam logic [3:0]  DEFAULT_BLANK_CODE = 4'hF;
    localparam logic [3:0]  MAX_DIGIT          = 4'd9;

    // Active-low anode pattern: digit 0 maps to bit n-1 (leftmost).
    function automatic logic [MAX_DIGITS-1:0] onehot_lo(input int unsigned index,
                                                        input int unsigned n);
        logic [MAX_DIGITS-1:0] pat;
        pat = '1;
        if (index < n) begin
            pat = ~(MAX_DIGITS'(1) << (n - 1 - index));
        end
        return pat;
    endfunction

endpackage

// File: rtl/digit_entry_display_if.sv
// Keypad-side inputs and display-side outputs of the digit entry display.
interface digit_entry_display_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic                  key_valid;
    logic [3:0]            key_val;
    logic                  btn_next;
    logic                  btn_back;
    logic [NUM_DIGITS-1:0] anode;
    logic [3:0]            hex_out;
    logic [NUM_DIGITS-1:0] led;
    logic                  full;

    modport master (
        output key_valid, key_val, btn_next, btn_back,
        input  anode, hex_out, led, full
    );

    modport slave (
        input  key_valid, key_val, btn_next, btn_back,
        output anode, hex_out, led, full
    );
endinterface

// File: rtl/digit_entry_display_button_edge.sv
// Two-flop synchroniser followed by a rising-edge detector (one-cycle pulse).
module button_edge (
    input  logic clock,
    input  logic reset_n,
    input  logic btn,
    output logic pulse
);
    // sync[1:0] is the synchroniser chain, sync[2] the previous synchronised level.
    logic [2:0] sync;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[1:0], btn};
        end
    end

    assign pulse = sync[1] & ~sync[2];
endmodule

// File: rtl/digit_entry_display.sv
// Keypad digit entry buffer with cursor and time-multiplexed seven-segment scan.
// Build macro CURSOR_BLINK_EN blinks the digit under the cursor.
module digit_entry_display
    import digit_display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SCAN_DIV_W = 18,
    parameter logic [3:0]  BLANK_CODE = DEFAULT_BLANK_CODE
) (
    input logic                   clock,
    input logic                   reset_n,
    digit_entry_display_if.slave  bus
);
    localparam int unsigned     IDX_W = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_DIGITS - 1);

    logic [3:0]            slots [NUM_DIGITS];
    logic [IDX_W-1:0]      cursor;
    logic [IDX_W-1:0]      scan_idx;
    logic [SCAN_DIV_W-1:0] prescale;
    logic                  next_pulse;
    logic                  back_pulse;
    logic                  key_write;
    logic                  all_set;
    logic                  disp_blank;
    logic [3:0]            disp_hex;
    logic [MAX_DIGITS-1:0] anode_pat;

    button_edge u_next (.clock(clock), .reset_n(reset_n), .btn(bus.btn_next), .pulse(next_pulse));
    button_edge u_back (.clock(clock), .reset_n(reset_n), .btn(bus.btn_back), .pulse(back_pulse));

    assign key_write = bus.key_valid && (bus.key_val <= MAX_DIGIT);

    // back > key write > next; the losers of a same-cycle collision are dropped.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                slots[i] <= BLANK_CODE;
            end
            cursor <= '0;
        end else if (back_pulse) begin
            slots[cursor] <= BLANK_CODE;
            if (cursor != '0) begin
                cursor <= cursor - 1'b1;
            end
        end else if (key_write) begin
            slots[cursor] <= bus.key_val;
            if (cursor != LAST) begin
                cursor <= cursor + 1'b1;
            end
        end else if (next_pulse) begin
            if (cursor != LAST) begin
                cursor <= cursor + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            prescale <= '0;
            scan_idx <= '0;
        end else begin
            prescale <= prescale + 1'b1;
            if (prescale == '1) begin
                scan_idx <= (scan_idx == LAST) ? '0 : scan_idx + 1'b1;
            end
        end
    end

`ifdef CURSOR_BLINK_EN
    logic [SCAN_DIV_W+3:0] blink_cnt;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            blink_cnt <= '0;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end
`endif

    always_comb begin
        disp_hex   = slots[scan_idx];
        disp_blank = (slots[scan_idx] == BLANK_CODE);
`ifdef CURSOR_BLINK_EN
        // Blink-on phase: a filled cursor digit goes dark, an empty one shows 8.
        if (scan_idx == cursor && blink_cnt[SCAN_DIV_W+3]) begin
            if (disp_blank) begin
                disp_blank = 1'b0;
                disp_hex   = 4'h8;
            end else begin
                disp_blank = 1'b1;
            end
        end
`endif
        anode_pat = onehot_lo(int'(scan_idx), NUM_DIGITS);
    end

    always_comb begin
        all_set = 1'b1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (slots[i] == BLANK_CODE) begin
                all_set = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            bus.anode   <= '1;
            bus.hex_out <= BLANK_CODE;
            bus.led     <= NUM_DIGITS'(1);
            bus.full    <= 1'b0;
        end else begin
            if (disp_blank) begin
                bus.anode   <= '1;
                bus.hex_out <= BLANK_CODE;
            end else begin
                bus.anode   <= anode_pat[NUM_DIGITS-1:0];
                bus.hex_out <= disp_hex;
            end
            bus.led  <= NUM_DIGITS'(1) << cursor;
            bus.full <= all_set;
        end
    end
endmodule

// File: tb/tb_digit_entry_display.sv
// Self-checking bench for digit_entry_display (4- and 6-digit instances, short scan).
module tb_digit_entry_display;

    localparam int SCAN_W = 3;
    localparam int DIV    = 8;

    logic clk = 1'b0;
    logic rst4 = 1'b0;
    logic rst6 = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    digit_entry_display_if #(.NUM_DIGITS(4)) bus4 ();
    digit_entry_display_if #(.NUM_DIGITS(6)) bus6 ();

    digit_entry_display #(.NUM_DIGITS(4), .SCAN_DIV_W(SCAN_W), .BLANK_CODE(4'hF)) dut4 (
        .clock(clk), .reset_n(rst4), .bus(bus4)
    );
    digit_entry_display #(.NUM_DIGITS(6), .SCAN_DIV_W(SCAN_W), .BLANK_CODE(4'hF)) dut6 (
        .clock(clk), .reset_n(rst6), .bus(bus6)
    );

    // Reference model: slot array, integer cursor, cycle count since reset.
    typedef struct packed {
        logic [7:0][3:0] slot;
        int              cursor;
        int              cyc;
        logic [2:0]      hn;
        logic [2:0]      hb;
        logic [7:0]      anode;
        logic [3:0]      hex;
        logic [7:0]      led;
        logic            full;
    } model_t;

    model_t m4, m6;

    function automatic model_t step(input model_t m, input int n, input logic rst_n,
                                    input logic kv, input logic [3:0] kval,
                                    input logic bn, input logic bb);
        model_t r;
        int     idx;
        logic   nxt, bck;
        r = m;
        if (!rst_n) begin
            r.slot   = '1;
            r.cursor = 0;
            r.cyc    = 0;
            r.hn     = '0;
            r.hb     = '0;
            r.anode  = '1;
            r.hex    = 4'hF;
            r.led    = 8'd1;
            r.full   = 1'b0;
            return r;
        end
        idx = (m.cyc / DIV) % n;
        if (m.slot[idx] == 4'hF) begin
            r.anode = '1;
            r.hex   = 4'hF;
        end else begin
            r.anode = ~(8'd1 << (n - 1 - idx));
            r.hex   = m.slot[idx];
        end
        r.led  = 8'd1 << m.cursor;
        r.full = 1'b1;
        for (int i = 0; i < n; i++) if (m.slot[i] == 4'hF) r.full = 1'b0;
        // a button edge becomes visible two clocks after it is first sampled
        nxt  = m.hn[1] & ~m.hn[2];
        bck  = m.hb[1] & ~m.hb[2];
        r.hn = {m.hn[1:0], bn};
        r.hb = {m.hb[1:0], bb};
        r.cyc = m.cyc + 1;
        if (bck) begin
            r.slot[m.cursor] = 4'hF;
            r.cursor = (m.cursor > 0) ? m.cursor - 1 : 0;
        end else if (kv && kval < 4'd10) begin
            r.slot[m.cursor] = kval;
            r.cursor = (m.cursor + 1 < n) ? m.cursor + 1 : n - 1;
        end else if (nxt) begin
            r.cursor = (m.cursor + 1 < n) ? m.cursor + 1 : n - 1;
        end
        return r;
    endfunction

    always @(posedge clk) begin
        m4 <= step(m4, 4, rst4, bus4.key_valid, bus4.key_val, bus4.btn_next, bus4.btn_back);
        m6 <= step(m6, 6, rst6, bus6.key_valid, bus6.key_val, bus6.btn_next, bus6.btn_back);
    end

    task automatic key4(input logic [3:0] v);
        @(negedge clk);
        bus4.key_valid = 1'b1;
        bus4.key_val   = v;
        @(negedge clk);
        bus4.key_valid = 1'b0;
    endtask

    task automatic key6(input logic [3:0] v);
        @(negedge clk);
        bus6.key_valid = 1'b1;
        bus6.key_val   = v;
        @(negedge clk);
        bus6.key_valid = 1'b0;
    endtask

    task automatic back4();
        @(negedge clk);
        bus4.btn_back = 1'b1;
        repeat (2) @(negedge clk);
        bus4.btn_back = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst4 = 1'b1;
        rst6 = 1'b1;
        for (int c = 0; c < 4 * DIV + 4; c++) begin
            @(negedge clk);
            checks++;
            if ({bus4.anode, bus4.hex_out, bus4.led, bus4.full} !== {4'b1111, 4'hF, 4'b0001, 1'b0}) begin
                errors++;
                $display("FAIL reset_outputs got %h want %h",
                         {bus4.anode, bus4.hex_out, bus4.led, bus4.full}, {4'b1111, 4'hF, 4'b0001, 1'b0});
            end
        end
    endtask

    task automatic test_entry();
        logic [3:0] seen;
        logic [3:0] last_hex;
        key4(4'd3);
        key4(4'd7);
        key4(4'd1);
        @(negedge clk);
        bus4.key_valid = 1'b1;
        bus4.key_val   = 4'd9;
        @(negedge clk);
        bus4.key_valid = 1'b0;
        checks++;
        if (bus4.full !== 1'b0) begin
            errors++;
            $display("FAIL full_early got %b want 0", bus4.full);
        end
        @(negedge clk);
        checks++;
        if (bus4.full !== 1'b1) begin
            errors++;
            $display("FAIL full_rise got %b want 1", bus4.full);
        end
        seen = '0;
        for (int c = 0; c < 4 * DIV + 2; c++) begin
            @(negedge clk);
            checks++;
            if ({bus4.anode, bus4.hex_out, bus4.led, bus4.full} !== {m4.anode[3:0], m4.hex, m4.led[3:0], m4.full}) begin
                errors++;
                $display("FAIL entry_scan got %h want %h",
                         {bus4.anode, bus4.hex_out, bus4.led, bus4.full}, {m4.anode[3:0], m4.hex, m4.led[3:0], m4.full});
            end
            if (bus4.anode == 4'b0111 && bus4.hex_out == 4'd3) seen[0] = 1'b1;
            if (bus4.anode == 4'b1011 && bus4.hex_out == 4'd7) seen[1] = 1'b1;
            if (bus4.anode == 4'b1101 && bus4.hex_out == 4'd1) seen[2] = 1'b1;
            if (bus4.anode == 4'b1110 && bus4.hex_out == 4'd9) seen[3] = 1'b1;
        end
        checks++;
        if (seen !== 4'b1111 || bus4.led !== 4'b1000) begin
            errors++;
            $display("FAIL entry_digits got seen=%b led=%b want seen=1111 led=1000", seen, bus4.led);
        end
        key4(4'd5);
        key4(4'hC);
        last_hex = 4'h0;
        for (int c = 0; c < 4 * DIV + 2; c++) begin
            @(negedge clk);
            checks++;
            if ({bus4.anode, bus4.hex_out, bus4.led, bus4.full} !== {m4.anode[3:0], m4.hex, m4.led[3:0], m4.full}) begin
                errors++;
                $display("FAIL overwrite_scan got %h want %h",
                         {bus4.anode, bus4.hex_out, bus4.led, bus4.full}, {m4.anode[3:0], m4.hex, m4.led[3:0], m4.full});
            end
            if (bus4.anode == 4'b1110) last_hex = bus4.hex_out;
        end
        checks++;
        if (last_hex !== 4'd5 || bus4.led !== 4'b1000 || bus4.full !== 1'b1) begin
            errors++;
            $display("FAIL overwrite_last got hex=%h led=%b full=%b want hex=5 led=1000 full=1",
                     last_hex, bus4.led, bus4.full);
        end
    endtask

    task automatic test_back();
        int lit_blank;
        back4();
        back4();
        lit_blank = 0;
        for (int c = 0; c < 4 * DIV + 2; c++) begin
            @(negedge clk);
            checks++;
            if ({bus4.anode, bus4.hex_out, bus4.led, bus4.full} !== {m4.anode[3:0], m4.hex, m4.led[3:0], m4.full}) begin
                errors++;
                $display("FAIL back_scan got %h want %h",
                         {bus4.anode, bus4.hex_out, bus4.led, bus4.full}, {m4.anode[3:0], m4.hex, m4.led[3:0], m4.full});
            end
            if (bus4.anode == 4'b1101 || bus4.anode == 4'b1110) lit_blank++;
        end
        checks++;
        if (lit_blank !== 0 || bus4.led !== 4'b0010 || bus4.full !== 1'b0) begin
            errors++;
            $display("FAIL back_state got lit=%0d led=%b full=%b want lit=0 led=0010 full=0",
                     lit_blank, bus4.led, bus4.full);
        end
    endtask

    task automatic test_priority();
        logic saw_slot0;
        @(negedge clk);
        bus4.btn_back = 1'b1;
        bus4.btn_next = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus4.key_valid = 1'b1;
        bus4.key_val   = 4'd4;
        @(negedge clk);
        bus4.key_valid = 1'b0;
        bus4.btn_back  = 1'b0;
        bus4.btn_next  = 1'b0;
        @(negedge clk);
        checks++;
        if (bus4.led !== 4'b0001) begin
            errors++;
            $display("FAIL priority_cursor got %b want 0001", bus4.led);
        end
        saw_slot0 = 1'b0;
        for (int c = 0; c < 4 * DIV + 2; c++) begin
            @(negedge clk);
            checks++;
            if ({bus4.anode, bus4.hex_out, bus4.led, bus4.full} !== {m4.anode[3:0], m4.hex, m4.led[3:0], m4.full}) begin
                errors++;
                $display("FAIL priority_scan got %h want %h",
                         {bus4.anode, bus4.hex_out, bus4.led, bus4.full}, {m4.anode[3:0], m4.hex, m4.led[3:0], m4.full});
            end
            if (bus4.anode == 4'b0111 && bus4.hex_out == 4'd3) saw_slot0 = 1'b1;
            if (bus4.anode == 4'b1011) saw_slot0 = 1'b0;
        end
        checks++;
        if (saw_slot0 !== 1'b1) begin
            errors++;
            $display("FAIL priority_slots got %b want 1 (slot0=3 kept, slot1 blank)", saw_slot0);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            checks++;
            if ({bus4.anode, bus4.hex_out, bus4.led, bus4.full} !== {m4.anode[3:0], m4.hex, m4.led[3:0], m4.full}) begin
                errors++;
                $display("FAIL random4 cycle %0d got %h want %h", c,
                         {bus4.anode, bus4.hex_out, bus4.led, bus4.full}, {m4.anode[3:0], m4.hex, m4.led[3:0], m4.full});
            end
            checks++;
            if ({bus6.anode, bus6.hex_out, bus6.led, bus6.full} !== {m6.anode[5:0], m6.hex, m6.led[5:0], m6.full}) begin
                errors++;
                $display("FAIL random6 cycle %0d got %h want %h", c,
                         {bus6.anode, bus6.hex_out, bus6.led, bus6.full}, {m6.anode[5:0], m6.hex, m6.led[5:0], m6.full});
            end
            bus4.key_valid = ($urandom_range(2, 0) == 0);
            bus4.key_val   = 4'($urandom_range(15, 0));
            if ($urandom_range(7, 0) == 0) bus4.btn_next = ~bus4.btn_next;
            if ($urandom_range(9, 0) == 0) bus4.btn_back = ~bus4.btn_back;
            bus6.key_valid = ($urandom_range(2, 0) == 0);
            bus6.key_val   = 4'($urandom_range(15, 0));
            if ($urandom_range(7, 0) == 0) bus6.btn_next = ~bus6.btn_next;
            if ($urandom_range(9, 0) == 0) bus6.btn_back = ~bus6.btn_back;
        end
        @(negedge clk);
        bus4.key_valid = 1'b0;
        bus4.btn_next  = 1'b0;
        bus4.btn_back  = 1'b0;
        bus6.key_valid = 1'b0;
        bus6.btn_next  = 1'b0;
        bus6.btn_back  = 1'b0;
    endtask

    task automatic test_mid_reset();
        key4(4'd2);
        key4(4'd6);
        key6(4'd8);
        @(negedge clk);
        rst4 = 1'b0;
        rst6 = 1'b0;
        @(negedge clk);
        rst4 = 1'b1;
        rst6 = 1'b1;
        checks++;
        if ({bus4.anode, bus4.hex_out, bus4.led, bus4.full} !== {4'b1111, 4'hF, 4'b0001, 1'b0}) begin
            errors++;
            $display("FAIL midreset4 got %h want %h",
                     {bus4.anode, bus4.hex_out, bus4.led, bus4.full}, {4'b1111, 4'hF, 4'b0001, 1'b0});
        end
        checks++;
        if ({bus6.anode, bus6.hex_out, bus6.led, bus6.full} !== {6'b111111, 4'hF, 6'b000001, 1'b0}) begin
            errors++;
            $display("FAIL midreset6 got %h want %h",
                     {bus6.anode, bus6.hex_out, bus6.led, bus6.full}, {6'b111111, 4'hF, 6'b000001, 1'b0});
        end
    endtask

    task automatic test_wrap6();
        logic [5:0] prev;
        int         wraps;
        for (int d = 0; d < 6; d++) key6(4'($urandom_range(9, 0)));
        prev  = '1;
        wraps = 0;
        for (int c = 0; c < 2 * 6 * DIV + 4; c++) begin
            @(negedge clk);
            checks++;
            if ({bus6.anode, bus6.hex_out, bus6.led, bus6.full} !== {m6.anode[5:0], m6.hex, m6.led[5:0], m6.full}) begin
                errors++;
                $display("FAIL wrap6_scan got %h want %h",
                         {bus6.anode, bus6.hex_out, bus6.led, bus6.full}, {m6.anode[5:0], m6.hex, m6.led[5:0], m6.full});
            end
            if (prev == 6'b111110 && bus6.anode == 6'b011111) wraps++;
            prev = bus6.anode;
        end
        checks++;
        if (wraps < 1 || bus6.full !== 1'b1 || bus6.led !== 6'b100000) begin
            errors++;
            $display("FAIL wrap6_index got wraps=%0d full=%b led=%b want wraps>=1 full=1 led=100000",
                     wraps, bus6.full, bus6.led);
        end
    endtask

    initial begin
        bus4.key_valid = 1'b0;
        bus4.key_val   = 4'h0;
        bus4.btn_next  = 1'b0;
        bus4.btn_back  = 1'b0;
        bus6.key_valid = 1'b0;
        bus6.key_val   = 4'h0;
        bus6.btn_next  = 1'b0;
        bus6.btn_back  = 1'b0;
        test_reset();
        test_entry();
        test_back();
        test_priority();
        test_random();
        test_mid_reset();
        test_wrap6();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
